sdram_port_arbiter: RTL

//  Shares the single SDRAM command port between two masters:
//   - m0: program loader, boot-time writes.
//   - m1: CPU load/store unit.

---
 rtl/sdram_port_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: two masters (m0 loader, m1 CPU LSU) share one SDRAM
// command port. Round-robin at transaction granularity, one command in
// flight, and a watchdog that aborts a command the controller never finishes.
//
// Handshake: mN_req is a level held until mN_fin; we/addr/wdata are stable
// while req is high. mem_req is a level held until mem_fin. mem_fin and
// mN_fin are single-cycle pulses. mem_rdata is valid only with mem_fin.
// mN_rdata is valid with mN_fin and holds afterwards.
module sdram_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_fin,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_fin,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_fin,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_FIN = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

    // Last tcnt value before the abort fires; unused when TIMEOUT is 0.
    localparam logic [CNT_W-1:0] TCNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TCNT_MAX  = '1;

    state_t            state_q, state_d;
    logic              last_q, last_d;       // 1 = m1 owned the previous transaction
    logic [CNT_W-1:0]  tcnt_q, tcnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        fin_q, fin_d;         // bit N -> mN_fin
    logic [1:0]        err_q, err_d;         // bit N -> mN_err
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              win1;

    // Next-state and datapath: arbitrate in IDLE, wait for completion or timeout, one-cycle DONE.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        tcnt_d      = tcnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_d     = grant_q;
        fin_d       = fin_q;
        err_d       = err_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        // m1 wins when it is the only requester, or on a tie when m0 went last.
        win1        = m1_req & (~m0_req | ~last_q);

        case (state_q)
            ST_IDLE: begin
                fin_d = 2'b00;
                err_d = 2'b00;
                if (m0_req || m1_req) begin
                    mem_we_d    = win1 ? m1_we    : m0_we;
                    mem_addr_d  = win1 ? m1_addr  : m0_addr;
                    mem_wdata_d = win1 ? m1_wdata : m0_wdata;
                    grant_d     = win1 ? 2'b10 : 2'b01;
                    last_d      = win1;
                    tcnt_d      = '0;
                    mem_req_d   = 1'b1;
                    state_d     = ST_WAIT_FIN;
                end
            end
            ST_WAIT_FIN: begin
                tcnt_d = (tcnt_q == TCNT_MAX) ? tcnt_q : tcnt_q + 1'b1;
                if (mem_fin) begin
                    // Completion beats a timeout landing on the same cycle.
                    mem_req_d = 1'b0;
                    fin_d     = grant_q;
                    err_d     = 2'b00;
                    if (!mem_we_q) begin
                        if (grant_q[0]) rdata0_d = mem_rdata;
                        if (grant_q[1]) rdata1_d = mem_rdata;
                    end
                    state_d = ST_DONE;
                end else if ((TIMEOUT != 0) && (tcnt_q == TCNT_LAST)) begin
                    mem_req_d = 1'b0;
                    fin_d     = grant_q;
                    err_d     = grant_q;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                fin_d   = 2'b00;
                err_d   = 2'b00;
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; m0 wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            tcnt_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            grant_q     <= 2'b00;
            fin_q       <= 2'b00;
            err_q       <= 2'b00;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            tcnt_q      <= tcnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            grant_q     <= grant_d;
            fin_q       <= fin_d;
            err_q       <= err_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign grant     = grant_q;
    assign m0_fin    = fin_q[0];
    assign m1_fin    = fin_q[1];
    assign m0_err    = err_q[0];
    assign m1_err    = err_q[1];
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule
